// File: rtl/exu_pkg.sv
// Shared encodings and decode helper for the OP-IMM / EBREAK execute unit.
// The decode function is used once at accept time, so the latched flags and the pulses agree.
package exu_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRI   = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;
  localparam logic [2:0] F3_PRIV  = 3'b000;

  localparam logic [6:0]  F7_SRLI    = 7'b0000000;
  localparam logic [6:0]  F7_SRAI    = 7'b0100000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    WB    = 2'd3
  } state_e;

  typedef struct packed {
    logic writes;
    logic shift;
    logic ebreak;
    logic illegal;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [11:0] imm);
    dec_t d;
    d = '0;
    case (op)
      OP_IMM: begin
        case (f3)
          F3_SLLI: begin
            if (imm[11:5] == F7_SRLI) begin
              d.writes = 1'b1;
              d.shift  = 1'b1;
            end else begin
              d.illegal = 1'b1;
            end
          end
          F3_SRI: begin
            if (imm[11:5] == F7_SRLI || imm[11:5] == F7_SRAI) begin
              d.writes = 1'b1;
              d.shift  = 1'b1;
            end else begin
              d.illegal = 1'b1;
            end
          end
          default: d.writes = 1'b1;
        endcase
      end
      SYSTEM: begin
        if (f3 == F3_PRIV && imm == IMM_EBREAK) d.ebreak = 1'b1;
        else d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exu_shifter.sv
// Iterative shifter: one bit per cycle while the counter is non-zero.
// step_o is the value after the next shift; done_o marks the final step.
module exu_shifter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] val_i,
  input  logic [4:0]      shamt_i,
  input  logic            right_i,
  input  logic            arith_i,
  output logic [XLEN-1:0] step_o,
  output logic            done_o
);

  logic [XLEN-1:0] val_q;
  logic [4:0]      cnt_q;
  logic            right_q;
  logic            arith_q;

  assign step_o = right_q ? {arith_q & val_q[XLEN-1], val_q[XLEN-1:1]}
                          : {val_q[XLEN-2:0], 1'b0};
  assign done_o = (cnt_q == 5'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      val_q   <= val_i;
      cnt_q   <= shamt_i;
      right_q <= right_i;
      arith_q <= arith_i;
    end else if (cnt_q != 5'd0) begin
      val_q <= step_o;
      cnt_q <= cnt_q - 5'd1;
    end
  end

endmodule

// File: rtl/exu.sv
// Execute/write-back unit: accepts one decoded OP-IMM/EBREAK instruction at a time and
// produces a single-cycle register-file write strobe. Handshake: accept on in_valid && in_ready.
module exu
  import exu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      ex_op,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [11:0]     ex_imm,
  input  logic [4:0]      ex_rd,
  output logic            wb_wen,
  output logic [4:0]      wb_waddr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            ex_busy,
  output logic            ex_illegal,
  output logic            ex_ebreak,
  output logic [1:0]      dbg_state
);

  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] src1_q;
  logic [11:0]     imm_q;
  logic [4:0]      rd_q;
  logic            writes_q;
  logic            shift_q;
  logic [XLEN-1:0] res_q;
  logic [4:0]      waddr_q;
  logic            wen_q;
  logic            ill_q;
  logic            ebk_q;

  logic            accept;
  dec_t            dec_in;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] alu_res;
  logic            sh_load;
  logic            sh_done;
  logic [XLEN-1:0] sh_step;
  logic            wb_fire;
  logic [XLEN-1:0] wb_val;

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign dec_in     = decode(ex_op, ex_funct3, ex_imm);
  assign imm_sext   = {{(XLEN-12){imm_q[11]}}, imm_q};
  assign sh_load    = (state_q == EXEC) && shift_q && (imm_q[4:0] != 5'd0);
  assign ex_busy    = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign wb_wen     = wen_q;
  assign wb_waddr   = waddr_q;
  assign wb_wdata   = res_q;
  assign ex_illegal = ill_q;
  assign ex_ebreak  = ebk_q;

  // A zero-length shift falls through to the default arm and writes src1 unchanged.
  always_comb begin
    alu_res = src1_q;
    case (f3_q)
      F3_ADDI:  alu_res = src1_q + imm_sext;
      F3_SLTI:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(imm_sext)};
      F3_SLTIU: alu_res = {{(XLEN-1){1'b0}}, src1_q < imm_sext};
      F3_XORI:  alu_res = src1_q ^ imm_sext;
      F3_ORI:   alu_res = src1_q | imm_sext;
      F3_ANDI:  alu_res = src1_q & imm_sext;
      default:  alu_res = src1_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC: begin
        if (!writes_q)    state_d = IDLE;
        else if (sh_load) state_d = SHIFT;
        else              state_d = WB;
      end
      SHIFT:   if (sh_done) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb_fire = ((state_q == EXEC) && writes_q && !sh_load) ||
                   ((state_q == SHIFT) && sh_done);
  assign wb_val  = (state_q == SHIFT) ? sh_step : alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      src1_q   <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      writes_q <= 1'b0;
      shift_q  <= 1'b0;
      res_q    <= RESET_VAL;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      ill_q    <= 1'b0;
      ebk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= accept && dec_in.illegal;
      ebk_q   <= accept && dec_in.ebreak;
      wen_q   <= wb_fire && (rd_q != 5'd0);
      if (accept) begin
        f3_q     <= ex_funct3;
        src1_q   <= ex_src1;
        imm_q    <= ex_imm;
        rd_q     <= ex_rd;
        writes_q <= dec_in.writes;
        shift_q  <= dec_in.shift;
      end
      // x0 writes leave the visible write-back registers holding the previous result.
      if (wb_fire && rd_q != 5'd0) begin
        res_q   <= wb_val;
        waddr_q <= rd_q;
      end
    end
  end

  exu_shifter #(.XLEN(XLEN)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .val_i   (src1_q),
    .shamt_i (imm_q[4:0]),
    .right_i (f3_q == F3_SRI),
    .arith_i (imm_q[11:5] == F7_SRAI),
    .step_o  (sh_step),
    .done_o  (sh_done)
  );

endmodule

// File: tb/tb_exu.sv
// Bench for exu: directed plan items, then random instructions against a reference model.
// Expected events carry their due cycle so latency is checked along with data.
module tb_exu;
  import exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  ex_op = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_src1 = '0;
  logic [11:0] ex_imm = '0;
  logic [4:0]  ex_rd = '0;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_busy;
  logic        ex_illegal;
  logic        ex_ebreak;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [70:0] exp_q[$];
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic        have_prev = 1'b0;
  int          prev_ready = 0;

  exu #(.XLEN(32), .RESET_VAL(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ex_op      (ex_op),
    .ex_funct3  (ex_funct3),
    .ex_src1    (ex_src1),
    .ex_imm     (ex_imm),
    .ex_rd      (ex_rd),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .ex_busy    (ex_busy),
    .ex_illegal (ex_illegal),
    .ex_ebreak  (ex_ebreak),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: kind 0 = write, 1 = illegal, 2 = ebreak; lat = extra shift cycles.
  task automatic ref_model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] s1,
                           input logic [11:0] imm, output int kind, output logic [31:0] res,
                           output int lat);
    logic signed [31:0] simm;
    int sh;
    simm = {{20{imm[11]}}, imm};
    sh = int'(imm[4:0]);
    kind = 1;
    res = '0;
    lat = 0;
    if (op == 7'b0010011) begin
      case (f3)
        3'd0: begin kind = 0; res = s1 + simm; end
        3'd2: begin kind = 0; res = ($signed(s1) < simm) ? 32'd1 : 32'd0; end
        3'd3: begin kind = 0; res = (s1 < $unsigned(simm)) ? 32'd1 : 32'd0; end
        3'd4: begin kind = 0; res = s1 ^ simm; end
        3'd6: begin kind = 0; res = s1 | simm; end
        3'd7: begin kind = 0; res = s1 & simm; end
        3'd1: if (imm[11:5] == 7'h00) begin kind = 0; res = s1 << sh; lat = sh; end
        default: begin
          if (imm[11:5] == 7'h00) begin kind = 0; res = s1 >> sh; lat = sh; end
          else if (imm[11:5] == 7'h20) begin kind = 0; res = $signed(s1) >>> sh; lat = sh; end
        end
      endcase
    end else if (op == 7'b1110011 && f3 == 3'd0 && imm == 12'h001) begin
      kind = 2;
    end
  endtask

  // Driver: called at a negedge; waits for in_ready, checks it came back on time,
  // pushes the expected event, then leaves junk on the bus with in_valid held high.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] s1,
                       input logic [11:0] imm, input logic [4:0] rd, output int acc);
    int n;
    int kind;
    int lat;
    logic [31:0] res;
    n = 0;
    acc = cyc;
    ex_op = op; ex_funct3 = f3; ex_src1 = s1; ex_imm = imm; ex_rd = rd;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout actual=0 required=1 cyc=%0d", cyc);
      in_valid = 1'b0;
      return;
    end
    if (have_prev) check("ready_cycle", 64'(cyc), 64'(prev_ready));
    acc = cyc;
    ref_model(op, f3, s1, imm, kind, res, lat);
    if (kind == 0) begin
      if (rd != 5'd0) exp_q.push_back({2'd0, rd, res, 32'(acc + 2 + lat)});
      prev_ready = acc + 3 + lat;
    end else begin
      exp_q.push_back({2'(kind), 5'd0, 32'd0, 32'(acc + 1)});
      prev_ready = acc + 2;
    end
    have_prev = 1'b1;
    @(posedge clk);
    #1;
    ex_op = 7'($urandom); ex_funct3 = 3'($urandom); ex_src1 = $urandom;
    ex_imm = 12'($urandom); ex_rd = 5'($urandom);
    @(negedge clk);
  endtask

  task automatic pop_check(input logic [1:0] k);
    logic [70:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event actual=kind%0d required=none cyc=%0d", k, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 64'(k), 64'(e[70:69]));
      check("ev_cycle", 64'(cyc), 64'(e[31:0]));
      if (k == 2'd0) begin
        check("wb_waddr", 64'(wb_waddr), 64'(e[68:64]));
        check("wb_wdata", 64'(wb_wdata), 64'(e[63:32]));
      end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (wb_wen) pop_check(2'd0);
      if (ex_illegal) pop_check(2'd1);
      if (ex_ebreak) pop_check(2'd2);
      check("busy_vs_ready", 64'(ex_busy), 64'(!in_ready));
      if (wb_wen) begin
        last_addr = wb_waddr;
        last_data = wb_wdata;
      end else begin
        check("hold_waddr", 64'(wb_waddr), 64'(last_addr));
        check("hold_wdata", 64'(wb_wdata), 64'(last_data));
      end
    end
  end

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_ready", 64'(in_ready), 64'(exp_ready));
    check("rst_wen", 64'(wb_wen), 64'd0);
    check("rst_waddr", 64'(wb_waddr), 64'd0);
    check("rst_wdata", 64'(wb_wdata), 64'd0);
    check("rst_busy", 64'(ex_busy), 64'd0);
    check("rst_illegal", 64'(ex_illegal), 64'd0);
    check("rst_ebreak", 64'(ex_ebreak), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    int acc;
    int r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] s1;
    logic [31:0] corners [4];
    corners[0] = 32'h0; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs(1'b1);

    // directed plan items
    issue(7'h13, 3'd0, 32'h5, 12'hFFF, 5'd3, acc);
    issue(7'h13, 3'd3, 32'h1, 12'hFFF, 5'd4, acc);
    issue(7'h13, 3'd2, 32'h1, 12'hFFF, 5'd5, acc);
    issue(7'h13, 3'd5, 32'h8000_0000, 12'h404, 5'd6, acc);
    issue(7'h13, 3'd5, 32'h8000_0000, 12'h004, 5'd7, acc);
    issue(7'h13, 3'd1, 32'h1234_5678, 12'h000, 5'd8, acc);
    issue(7'h13, 3'd1, 32'h1234_5678, 12'h400, 5'd9, acc);
    issue(7'h73, 3'd0, 32'h0, 12'h001, 5'd0, acc);
    issue(7'h13, 3'd0, 32'h7, 12'h001, 5'd0, acc);
    @(negedge clk);
    check("rd0_in_wb", 64'(dbg_state), 64'(WB));
    check("rd0_no_wen", 64'(wb_wen), 64'd0);
    issue(7'h13, 3'd1, 32'h0000_0001, 12'h01F, 5'd10, acc);

    // reset in cycle 5 of a 20-bit SRAI: the instruction must vanish
    issue(7'h13, 3'd5, 32'hC000_1234, 12'h414, 5'd11, acc);
    in_valid = 1'b0;
    while (cyc < acc + 5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    have_prev = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs(1'b1);
    repeat (30) @(negedge clk);
    issue(7'h13, 3'd0, 32'h5, 12'hFFF, 5'd3, acc);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      s1 = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      imm = 12'($urandom);
      f3 = 3'($urandom);
      if (r < 7) begin
        op = 7'h13;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          case ($urandom_range(0, 3))
            0, 1: imm[11:5] = 7'h00;
            2: imm[11:5] = 7'h20;
            default: ;
          endcase
        end
      end else if (r == 7) begin
        op = 7'h73; f3 = 3'd0; imm = 12'h001;
      end else if (r == 8) begin
        op = 7'h73;
      end else begin
        op = 7'($urandom);
      end
      issue(op, f3, s1, imm, 5'($urandom), acc);
    end

    // drain
    in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
